// File: rtl/gpio_link_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : gpio_link_slave_if
// Purpose  : Register bus between the GPIO link responder (master side) and
//            the fabric register block (slave side).
// Revision : 1.0 - initial release
// ============================================================================
interface gpio_link_slave_if #(
   parameter int ADDR_W = 7
);
   logic [ADDR_W-1:0] reg_addr;
   logic [7:0]        reg_wdata;
   logic              reg_wr_en;
   logic              reg_rd_en;
   logic [7:0]        reg_rdata;

   modport master (
      output reg_addr,
      output reg_wdata,
      output reg_wr_en,
      output reg_rd_en,
      input  reg_rdata
   );

   modport slave (
      input  reg_addr,
      input  reg_wdata,
      input  reg_wr_en,
      input  reg_rd_en,
      output reg_rdata
   );
endinterface
`default_nettype wire

// File: rtl/gpio_link_slave.sv
`default_nettype none
// ============================================================================
// Module   : gpio_link_slave
// Purpose  : Fabric-side responder for the bit-banged SPI mode-0 link on the
//            MCU GPIO lines. Synchronises SCLK/CS_N/MOSI, decodes a command
//            byte (rw + address) followed by data bytes, drives a register
//            bus and returns read data / write echo on MISO.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_link_slave #(
   parameter int ADDR_W      = 7,
   parameter int SYNC_STAGES = 2,
   parameter int AUTO_INC    = 1
) (
   input  wire logic        ppm_clk,
   input  wire logic        rst_n,
   input  wire logic        mcu_sclk,
   input  wire logic        mcu_cs_n,
   input  wire logic        mcu_mosi,
   input  wire logic [2:0]  mcu_oe_n,
   output logic             mcu_miso,
   gpio_link_slave_if.master reg_bus,
   output logic             busy,
   output logic             abort_pulse,
   output logic [15:0]      frame_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMD  = 2'd1,
      S_DATA = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] c_addr_step  = ADDR_W'(AUTO_INC);
   localparam logic [1:0]        c_flush_done = 2'(SYNC_STAGES);

   state_t r_state;
   state_t w_state_nxt;

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_oe_sync;

   logic w_sclk;
   logic w_mosi;
   logic w_cs_eff;
   logic r_sclk_d;
   logic r_cs_d;
   logic w_sclk_rise;
   logic w_sclk_fall;
   logic w_cs_rise;
   logic w_cs_fall;
   logic [1:0] r_flush;
   logic r_armed;

   logic [2:0] r_bit_cnt;
   logic [6:0] r_rx;
   logic [7:0] w_byte;
   logic w_in_frame;
   logic w_in_data;
   logic w_byte_done;
   logic w_abort;
   logic w_frame_inc;

   logic              r_rw;
   logic              r_data_seen;
   logic [7:0]        r_tx;
   logic              r_miso;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_wdata;
   logic              r_wr_req;
   logic              r_rd_req;
   logic              r_wr_en;
   logic              r_rd_en;
   logic              r_load;
   logic              r_abort;
   logic [15:0]       r_frame_cnt;

   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
   assign w_cs_eff    = r_cs_sync[SYNC_STAGES-1] | r_oe_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk & r_sclk_d;
   assign w_cs_rise   = w_cs_eff & ~r_cs_d;
   assign w_cs_fall   = ~w_cs_eff & r_cs_d;
   assign w_byte      = {r_rx, w_mosi};

   // Input synchronisers; presets model an idle, deselected link
   always_ff @(posedge ppm_clk) begin
      if (!rst_n) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_oe_sync   <= '1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], mcu_sclk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], mcu_cs_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mcu_mosi};
         r_oe_sync   <= {r_oe_sync[SYNC_STAGES-2:0], |mcu_oe_n};
      end
   end

   // Edge history; a frame may only start once a real deselect has been seen
   // after reset, so a frame cut by reset is not re-decoded from mid-byte
   always_ff @(posedge ppm_clk) begin
      if (!rst_n) begin
         r_sclk_d <= 1'b0;
         r_cs_d   <= 1'b1;
         r_flush  <= 2'd0;
         r_armed  <= 1'b0;
      end else begin
         r_sclk_d <= w_sclk;
         r_cs_d   <= w_cs_eff;
         if (r_flush != c_flush_done) begin
            r_flush <= r_flush + 2'd1;
         end
         if ((r_flush == c_flush_done) && w_cs_eff) begin
            r_armed <= 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge ppm_clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state plus frame-end qualifiers; an sclk edge coinciding with the
   // deselect is counted before deciding whether the byte was cut short
   always_comb begin
      w_state_nxt = r_state;
      w_in_frame  = (r_state != S_IDLE);
      w_in_data   = (r_state == S_DATA) || (r_state == S_HOLD);
      w_byte_done = w_in_frame && w_sclk_rise && (r_bit_cnt == 3'd7);
      w_abort     = 1'b0;
      w_frame_inc = 1'b0;
      if (w_in_frame && w_cs_rise) begin
         w_abort     = w_sclk_rise ? (r_bit_cnt != 3'd7) : (r_bit_cnt != 3'd0);
         w_frame_inc = r_data_seen || (w_in_data && w_byte_done);
      end
      case (r_state)
         S_IDLE: begin
            if (w_cs_fall && r_armed) begin
               w_state_nxt = S_CMD;
            end
         end
         S_CMD: begin
            if (w_cs_rise) begin
               w_state_nxt = S_IDLE;
            end else if (w_byte_done) begin
               w_state_nxt = S_DATA;
            end
         end
         S_DATA, S_HOLD: begin
            if (w_cs_rise) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Shifting, command decode, register strobes, MISO and frame counting
   always_ff @(posedge ppm_clk) begin
      if (!rst_n) begin
         r_bit_cnt   <= 3'd0;
         r_rx        <= 7'd0;
         r_rw        <= 1'b0;
         r_data_seen <= 1'b0;
         r_tx        <= 8'd0;
         r_miso      <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= 8'd0;
         r_wr_req    <= 1'b0;
         r_rd_req    <= 1'b0;
         r_wr_en     <= 1'b0;
         r_rd_en     <= 1'b0;
         r_load      <= 1'b0;
         r_abort     <= 1'b0;
         r_frame_cnt <= 16'd0;
      end else begin
         r_wr_req <= 1'b0;
         r_rd_req <= 1'b0;
         r_wr_en  <= r_wr_req;
         r_rd_en  <= r_rd_req;
         r_load   <= r_rd_en;
         r_abort  <= w_abort;
         if (w_frame_inc) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         // A write address advances only after its strobe has been presented
         if (r_wr_en) begin
            r_addr <= r_addr + c_addr_step;
         end
         if (!w_in_frame) begin
            r_bit_cnt   <= 3'd0;
            r_data_seen <= 1'b0;
         end else begin
            if (w_sclk_rise) begin
               r_rx      <= w_byte[6:0];
               r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_byte_done) begin
               if (r_state == S_CMD) begin
                  r_rw   <= w_byte[7];
                  r_addr <= w_byte[ADDR_W-1:0];
                  if (w_byte[7]) begin
                     r_rd_req <= 1'b1;
                  end else begin
                     r_tx <= w_byte;
                  end
               end else begin
                  r_data_seen <= 1'b1;
                  if (r_rw) begin
                     r_addr   <= r_addr + c_addr_step;
                     r_rd_req <= 1'b1;
                  end else begin
                     r_wdata  <= w_byte;
                     r_wr_req <= 1'b1;
                     r_tx     <= w_byte;
                  end
               end
            end
            if (w_sclk_fall && w_in_data) begin
               r_miso <= r_tx[7];
               r_tx   <= {r_tx[6:0], 1'b0};
            end
            if (w_cs_rise) begin
               r_bit_cnt   <= 3'd0;
               r_data_seen <= 1'b0;
            end
         end
         // Read data arrives one cycle after the read strobe
         if (r_load) begin
            r_tx <= reg_bus.reg_rdata;
         end
         if (!w_in_data) begin
            r_miso <= 1'b0;
         end
      end
   end

   assign mcu_miso          = r_miso;
   assign reg_bus.reg_addr  = r_addr;
   assign reg_bus.reg_wdata = r_wdata;
   assign reg_bus.reg_wr_en = r_wr_en;
   assign reg_bus.reg_rd_en = r_rd_en;
   assign busy              = (r_state != S_IDLE);
   assign abort_pulse       = r_abort;
   assign frame_cnt         = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gpio_link_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_link_slave
// Purpose  : Directed, table-driven bench for gpio_link_slave. An MCU model
//            bit-bangs mode-0 frames; a register-file model answers reads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_link_slave;

   localparam int H = 6;   // sclk half period in clk cycles

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mcu_sclk = 1'b0;
   logic        mcu_cs_n = 1'b1;
   logic        mcu_mosi = 1'b0;
   logic [2:0]  mcu_oe_n = 3'b000;
   logic        mcu_miso;
   logic        busy;
   logic        abort_pulse;
   logic [15:0] frame_cnt;

   gpio_link_slave_if #(.ADDR_W(7)) bus ();

   gpio_link_slave #(
      .ADDR_W      (7),
      .SYNC_STAGES (2),
      .AUTO_INC    (1)
   ) dut (
      .ppm_clk     (clk),
      .rst_n       (rst_n),
      .mcu_sclk    (mcu_sclk),
      .mcu_cs_n    (mcu_cs_n),
      .mcu_mosi    (mcu_mosi),
      .mcu_oe_n    (mcu_oe_n),
      .mcu_miso    (mcu_miso),
      .reg_bus     (bus),
      .busy        (busy),
      .abort_pulse (abort_pulse),
      .frame_cnt   (frame_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Register file answering the bus
   logic [7:0] mem [128];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
         mem[7'h12]    <= 8'h3C;
         bus.reg_rdata <= 8'h00;
      end else begin
         if (bus.reg_rd_en) bus.reg_rdata <= mem[bus.reg_addr];
         if (bus.reg_wr_en) mem[bus.reg_addr] <= bus.reg_wdata;
      end
   end

   // Bus monitor
   int         wr_n = 0, rd_n = 0, abort_hi = 0, viol = 0, wr_lat = 0, last_rise = 0;
   logic [6:0] wr_a [64];
   logic [7:0] wr_d [64];
   logic [6:0] rd_a [64];
   logic       prev_wr = 1'b0, prev_rd = 1'b0;
   always @(negedge clk) begin
      if (bus.reg_wr_en) begin
         if (!prev_wr) wr_lat = cyc - last_rise;
         if (wr_n < 64) begin
            wr_a[wr_n] = bus.reg_addr;
            wr_d[wr_n] = bus.reg_wdata;
         end
         wr_n++;
      end
      if (bus.reg_rd_en) begin
         if (rd_n < 64) rd_a[rd_n] = bus.reg_addr;
         rd_n++;
      end
      if (bus.reg_wr_en && bus.reg_rd_en) viol++;
      if (bus.reg_wr_en && prev_wr) viol++;
      if (bus.reg_rd_en && prev_rd) viol++;
      if (abort_pulse) abort_hi++;
      prev_wr = bus.reg_wr_en;
      prev_rd = bus.reg_rd_en;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sclk_bit(input logic b, output logic m);
      mcu_mosi = b;
      repeat (H) @(negedge clk);
      m = mcu_miso;
      mcu_sclk  = 1'b1;
      last_rise = cyc;
      repeat (H) @(negedge clk);
      mcu_sclk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic [7:0] m);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         sclk_bit(b[i], s);
         m[i] = s;
      end
   endtask

   typedef struct {
      logic [7:0]  cmd;
      int          nbytes;
      int          cut_bits;   // -1: full bytes; else first data byte cut after N bits
      bit          use_oe;
      logic [23:0] din;        // byte k at [k*8 +: 8]
      int          exp_wr;
      logic [20:0] exp_a;      // write address k at [k*7 +: 7]
      logic [23:0] exp_d;
      int          exp_rd;
      logic [6:0]  exp_rd_a;
      logic [23:0] exp_miso;
      int          exp_abort;
      logic [15:0] exp_frame;
   } vec_t;

   function automatic vec_t mk(input logic [7:0] cmd, input int nb, input int cut,
                               input bit oe, input logic [23:0] din, input int ewr,
                               input logic [20:0] ea, input logic [23:0] ed,
                               input int erd, input logic [6:0] era,
                               input logic [23:0] em, input int eab,
                               input logic [15:0] ef);
      vec_t v;
      v.cmd = cmd; v.nbytes = nb; v.cut_bits = cut; v.use_oe = oe; v.din = din;
      v.exp_wr = ewr; v.exp_a = ea; v.exp_d = ed; v.exp_rd = erd; v.exp_rd_a = era;
      v.exp_miso = em; v.exp_abort = eab; v.exp_frame = ef;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      int wr0, rd0, ab0;
      logic [7:0] mb, bv;
      logic s;
      wr0 = wr_n; rd0 = rd_n; ab0 = abort_hi;
      mcu_cs_n = 1'b0;
      repeat (H) @(negedge clk);
      chk($sformatf("v%0d busy_start", idx), busy, 1);
      send_byte(v.cmd, mb);
      for (int k = 0; k < v.nbytes; k++) begin
         bv = v.din[k*8 +: 8];
         if (v.cut_bits >= 0) begin
            for (int b = 0; b < v.cut_bits; b++) sclk_bit(bv[7-b], s);
         end else begin
            send_byte(bv, mb);
            chk($sformatf("v%0d miso_byte%0d", idx, k), mb, v.exp_miso[k*8 +: 8]);
         end
      end
      repeat (H) @(negedge clk);
      if (v.use_oe) mcu_oe_n = 3'b001;
      else          mcu_cs_n = 1'b1;
      repeat (12) @(negedge clk);
      if (v.use_oe) begin
         mcu_cs_n = 1'b1;
         repeat (4) @(negedge clk);
         mcu_oe_n = 3'b000;
         repeat (6) @(negedge clk);
      end
      chk($sformatf("v%0d busy_end", idx), busy, 0);
      chk($sformatf("v%0d wr_count", idx), wr_n - wr0, v.exp_wr);
      for (int k = 0; k < v.exp_wr; k++) begin
         if (wr0 + k < 64) begin
            chk($sformatf("v%0d wr_addr%0d", idx, k), wr_a[wr0+k], v.exp_a[k*7 +: 7]);
            chk($sformatf("v%0d wr_data%0d", idx, k), wr_d[wr0+k], v.exp_d[k*8 +: 8]);
         end
      end
      if (v.exp_wr > 0) chk($sformatf("v%0d wr_latency", idx), wr_lat, 4);
      chk($sformatf("v%0d rd_count", idx), rd_n - rd0, v.exp_rd);
      if (v.exp_rd > 0 && rd0 < 64) chk($sformatf("v%0d rd_addr", idx), rd_a[rd0], v.exp_rd_a);
      chk($sformatf("v%0d abort_cycles", idx), abort_hi - ab0, v.exp_abort);
      chk($sformatf("v%0d frame_cnt", idx), frame_cnt, v.exp_frame);
   endtask

   vec_t vecs [7];

   initial begin
      logic [7:0] mb;
      logic s;
      int wr0, ab0;

      //            cmd    nb cut oe din        ewr ea                         ed         erd era    miso       ab frame
      vecs[0] = mk(8'h05, 1, -1, 0, 24'h0000A5, 1, 21'h05,                    24'h0000A5, 0, 7'h00, 24'h000005, 0, 16'd1);
      vecs[1] = mk(8'h92, 1, -1, 0, 24'h000000, 0, 21'h0,                     24'h0,      2, 7'h12, 24'h00003C, 0, 16'd2);
      vecs[2] = mk(8'h7E, 3, -1, 0, 24'h332211, 3, {7'h00, 7'h7F, 7'h7E},     24'h332211, 0, 7'h00, 24'h22117E, 0, 16'd3);
      vecs[3] = mk(8'h05, 1,  4, 0, 24'h0000A5, 0, 21'h0,                     24'h0,      0, 7'h00, 24'h0,      1, 16'd3);
      vecs[4] = mk(8'h05, 1,  3, 1, 24'h0000A5, 0, 21'h0,                     24'h0,      0, 7'h00, 24'h0,      1, 16'd3);
      vecs[5] = mk(8'hFF, 2, -1, 0, 24'h000000, 0, 21'h0,                     24'h0,      3, 7'h7F, 24'h003322, 0, 16'd4);
      vecs[6] = mk(8'h10, 2, -1, 0, 24'h007E81, 2, {7'h00, 7'h11, 7'h10},     24'h007E81, 0, 7'h00, 24'h008110, 0, 16'd5);

      // Reset state
      repeat (4) @(negedge clk);
      chk("rst miso", mcu_miso, 0);
      chk("rst addr", bus.reg_addr, 0);
      chk("rst wdata", bus.reg_wdata, 0);
      chk("rst strobes", {bus.reg_wr_en, bus.reg_rd_en}, 0);
      chk("rst busy", busy, 0);
      chk("rst abort", abort_pulse, 0);
      chk("rst frame_cnt", frame_cnt, 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Link held deselected by oe_n from the start of the frame
      wr0 = wr_n;
      mcu_oe_n = 3'b001;
      mcu_cs_n = 1'b0;
      repeat (H) @(negedge clk);
      send_byte(8'h05, mb);
      send_byte(8'hA5, mb);
      chk("oe_idle busy", busy, 0);
      chk("oe_idle wr_count", wr_n - wr0, 0);
      mcu_cs_n = 1'b1;
      repeat (4) @(negedge clk);
      mcu_oe_n = 3'b000;
      repeat (10) @(negedge clk);
      chk("oe_idle frame_cnt", frame_cnt, 5);

      // Reset in the middle of a write data byte
      wr0 = wr_n; ab0 = abort_hi;
      mcu_cs_n = 1'b0;
      repeat (H) @(negedge clk);
      send_byte(8'h05, mb);
      sclk_bit(1'b1, s); sclk_bit(1'b0, s); sclk_bit(1'b1, s);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst busy", busy, 0);
      chk("midrst addr", bus.reg_addr, 0);
      chk("midrst frame_cnt", frame_cnt, 0);
      chk("midrst miso", mcu_miso, 0);
      sclk_bit(1'b0, s); sclk_bit(1'b0, s); sclk_bit(1'b1, s);
      sclk_bit(1'b0, s); sclk_bit(1'b1, s);
      chk("midrst busy_after", busy, 0);
      repeat (H) @(negedge clk);
      mcu_cs_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("midrst wr_count", wr_n - wr0, 0);
      chk("midrst abort", abort_hi - ab0, 0);
      chk("midrst wdata", bus.reg_wdata, 0);
      chk("midrst frame_after", frame_cnt, 0);
      run_vec(mk(8'h05, 1, -1, 0, 24'h00005A, 1, 21'h05, 24'h00005A, 0, 7'h00,
                 24'h000005, 0, 16'd1), 7);

      chk("strobe_rules", viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gpio_link_slave.md
Name: gpio_link_slave

Overview:
- Fabric-side responder for the 4-line MCU GPIO link carried on the hard MCU's gpio_h0..gpio_h3.
- The MCU bit-bangs an SPI-mode-0 frame: gpio_h0_out is SCLK, gpio_h1_out is CS_N, gpio_h2_out is MOSI, and gpio_h3_in is MISO.
- This block synchronises the lines and decodes command/data bytes. It drives a simple register bus into fabric logic and returns read data on MISO.

Parameters:
- ADDR_W, 7, register address width; legal range 1..7; taken from the low bits of the command byte.
- SYNC_STAGES, 2, synchroniser depth on sclk/cs_n/mosi; legal range 2..3.
- AUTO_INC, 1, 1 means the address increments after each data byte in a burst; 0 means the address is held.

Ports:
- ppm_clk  input  1  single block clock, same clock as the MCU interface.
- rst_n  input  1  reset, synchronous, active-low.
- mcu_sclk  input  1  from gpio_h0_out.
- mcu_cs_n  input  1  from gpio_h1_out.
- mcu_mosi  input  1  from gpio_h2_out.
- mcu_oe_n  input  3  gpio_h2..h0_oe_n; any bit high means the link is deselected.
- mcu_miso  output  1  to gpio_h3_in.
- reg_addr  output  ADDR_W  register address.
- reg_wdata  output  8  write data.
- reg_wr_en  output  1  one-cycle write strobe.
- reg_rd_en  output  1  one-cycle read strobe.
- reg_rdata  input  8  read data, valid 1 cycle after reg_rd_en.
- busy  output  1  high while a frame is active.
- abort_pulse  output  1  one-cycle pulse when a frame ends mid-byte.
- frame_cnt  output  16  count of completed bytes-bearing frames; wraps.

Behaviour:
- Reset: rst_n sampled on the ppm_clk rising edge while low clears everything.
  - Outputs: mcu_miso=0, reg_addr=0, reg_wdata=0, reg_wr_en=0, reg_rd_en=0, busy=0, abort_pulse=0, frame_cnt=0.
  - State returns to IDLE.
  - Synchronisers preset to sclk=0, cs_n=1, mosi=0.
  - Reset mid-frame discards the frame; no strobe is issued.
- Input qualification: effective cs_n = sync(cs_n) OR (|mcu_oe_n); the |mcu_oe_n term is synchronised with the same depth.
- Edge detection: edges are detected on synchronised sclk. Supported SCLK rate is ≤ ppm_clk/8, i.e. each half-period is ≥ 4 cycles.
- Bit order: MSB first. MOSI is sampled on sclk rising edges. MISO updates on sclk falling edges.
- State machine IDLE, CMD, DATA, HOLD:
  - IDLE: busy=0. Effective cs_n falling → CMD, with bit_cnt=0 and busy=1.
  - CMD: shift 8 bits.
    - On the 8th rising edge: bit7 = rw (1 = read); reg_addr <= cmd[ADDR_W-1:0]; unused address bits ignored.
    - If rw=1, assert reg_rd_en for exactly one cycle, on the cycle after the 8th edge is detected.
    - Capture reg_rdata into the tx shifter on the following cycle. The first falling edge of the DATA phase then drives tx[7].
    - → DATA.
  - DATA: shift 8 bits.
    - Write, on the 8th rising edge: reg_wdata <= byte; reg_wr_en high for one cycle on the next cycle.
    - Read: the 8th rising edge completes the byte; no strobe is issued.
    - Then reg_addr += AUTO_INC, wrapping modulo 2^ADDR_W.
    - Burst read: issue the next reg_rd_en one cycle after the address update, and reload the tx shifter before the next falling edge.
    - Remain in DATA for bursts.
  - HOLD: entered when a write burst would wrap and AUTO_INC=0. It is not otherwise used and is reserved; the implementation may fold HOLD into DATA.
- MISO:
  - In CMD and IDLE, mcu_miso=0.
  - In DATA-read, mcu_miso follows the tx shifter MSB.
  - In DATA-write, mcu_miso echoes the previous received byte, shifted, which supports MCU loopback check.
- Frame end: effective cs_n rising → IDLE, busy=0 next cycle.
  - If bit_cnt≠0: abort_pulse=1 for one cycle; the partial byte is discarded; no reg_wr_en.
  - If at least one DATA byte completed: frame_cnt += 1, independent of abort.
- Simultaneous cs_n rise and 8th sclk rise: the edge is processed first, so the byte completes and its strobe issues; no abort.
- Strobe rules: reg_wr_en and reg_rd_en are never high in the same cycle, and each is never high for more than 1 cycle.
- Latency: MOSI pin to strobe is SYNC_STAGES+2 cycles after the 8th SCLK rising edge reaches the pin.

Test Plan:
- Write: cmd 0x05, data 0xA5, cs_n high → one reg_wr_en with reg_addr=0x05, reg_wdata=0xA5; frame_cnt=1; abort_pulse never high.
- Read: cmd 0x92, reg_rdata=0x3C one cycle after reg_rd_en → reg_addr=0x12; MISO bits during data phase = 0,0,1,1,1,1,0,0.
- Burst write, AUTO_INC=1: cmd 0x7E, data 0x11/0x22/0x33 → writes at addr 0x7E, 0x7F, 0x00 with those values; frame_cnt +1.
- Abort: cmd 0x05, then cs_n high after 4 data bits → no reg_wr_en; abort_pulse exactly 1 cycle; frame_cnt unchanged.
- oe_n: mcu_oe_n[0] set high after 3 data bits → same response as abort; cs_n low with oe_n=3'b001 from frame start → stays IDLE, busy=0.
- Reset: rst_n low for 1 cycle mid-DATA, then the MCU finishes the byte → no strobe; all outputs at reset values; the next full frame decodes normally.
